// File: rtl/aes_spi_responder.sv
// -----------------------------------------------------------------------------
// aes_spi_responder
//
// Serial front end for an AES cipher core. A frame is: 128 data bits, then
// NK*32 key bits (both sampled on sdi, first bit lands at index 0). After that
// come GAP turnaround cycles and 128 result bits driven on sdo, MSB first.
// The core is kicked with a one-cycle core_start right after the last key bit.
// Its core_done pulse is honoured only during the turnaround window. Raising cs
// aborts the frame on the next edge. When a frame ends with cs still low, the
// block goes straight to the next frame.
//
// Parameters
//   NK  : key length in 32-bit words (4, 6 or 8)
//   GAP : turnaround cycles between last key bit and first result bit (1..15)
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   cs            : chip select, active low
//   sdi / sdo     : serial in / serial out
//   core_start    : one-cycle start pulse to the cipher core
//   core_data     : received block  [0:127], bit 0 received first
//   core_key      : received key    [0:NK*32-1], bit 0 received first
//   core_done     : one-cycle pulse, core_result valid
//   core_result   : cipher core output [127:0]
//   frame_done    : one-cycle pulse alongside the last result bit
//   err           : (only with AES_SPI_TIMEOUT_EN) sticky flag, set when the
//                   turnaround window closes with no result captured
//
// Optional feature macro: AES_SPI_TIMEOUT_EN
// -----------------------------------------------------------------------------
module aes_spi_responder #(
   parameter int NK  = 4,
   parameter int GAP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cs,
   input  logic             sdi,
   output logic             sdo,
   output logic             core_start,
   output logic [0:127]     core_data,
   output logic [0:NK*32-1] core_key,
   input  logic             core_done,
   input  logic [127:0]     core_result,
   output logic             frame_done
`ifdef AES_SPI_TIMEOUT_EN
   ,
   output logic             err
`endif
);

   localparam int         KEY_BITS  = NK * 32;
   localparam int         KW        = $clog2(KEY_BITS);
   localparam logic [7:0] DATA_LAST = 8'd127;
   localparam logic [7:0] KEY_LAST  = 8'(KEY_BITS - 1);
   localparam logic [7:0] GAP_LAST  = 8'(GAP - 1);
   localparam logic [7:0] TX_LAST   = 8'd127;

   typedef enum logic [2:0] {IDLE, RX_DATA, RX_KEY, WAIT, TX} state_t;

   state_t       state, next_state;
   logic [7:0]   cnt;
   logic         start_next;
   logic [127:0] res;
`ifdef AES_SPI_TIMEOUT_EN
   logic         got;
`endif

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      start_next = 1'b0;
      if (cs) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    next_state = RX_DATA;
            RX_DATA: if (cnt == DATA_LAST) next_state = RX_KEY;
            RX_KEY:  if (cnt == KEY_LAST) begin
                        next_state = WAIT;
                        start_next = 1'b1;
                     end
            WAIT:    if (cnt == GAP_LAST) next_state = TX;
            TX:      if (cnt == TX_LAST) next_state = RX_DATA;
            default: next_state = IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // State register and bit counter
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && next_state == RX_DATA)
            cnt <= 8'd1;            // the leaving-IDLE edge already took data bit 0
         else if (next_state != state || state == IDLE)
            cnt <= '0;
         else
            cnt <= cnt + 8'd1;
      end
   end

   // -------------------------------------------------------------------------
   // Datapath: receive shift-in, core handshake, result capture
   // -------------------------------------------------------------------------
   // NOTE: core_data, core_key and the result register are plain flops (not a
   // RAM), so they are cleared by reset like any other state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_start <= 1'b0;
         core_data  <= '0;
         core_key   <= '0;
         res        <= '0;
`ifdef AES_SPI_TIMEOUT_EN
         got        <= 1'b0;
         err        <= 1'b0;
`endif
      end else begin
         core_start <= start_next;
         // cs high wins over everything, including a coincident core_done.
         if (!cs) begin
            case (state)
               IDLE:    core_data[0]            <= sdi;
               RX_DATA: core_data[cnt[6:0]]     <= sdi;
               RX_KEY:  core_key[cnt[KW-1:0]]   <= sdi;
               WAIT: begin
                  if (core_done) begin
                     res <= core_result;
`ifdef AES_SPI_TIMEOUT_EN
                     got <= 1'b1;
`endif
                  end
`ifdef AES_SPI_TIMEOUT_EN
                  // Window closing empty-handed: flag it and send zeros.
                  if (cnt == GAP_LAST && !core_done && !got) begin
                     res <= '0;
                     err <= 1'b1;
                  end
`endif
               end
               default: ;
            endcase
         end
`ifdef AES_SPI_TIMEOUT_EN
         if (start_next)
            got <= 1'b0;
`endif
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: index the result register rather than shifting it, so a frame
   // that misses core_done resends the previous result intact.
   // -------------------------------------------------------------------------
   always_comb begin
      sdo        = 1'b0;
      frame_done = 1'b0;
      if (state == TX) begin
         sdo        = res[7'd127 - cnt[6:0]];
         frame_done = (cnt == TX_LAST);
      end
   end

endmodule

// File: tb/tb_aes_spi_responder.sv
`timescale 1ns/1ps
module tb_aes_spi_responder;

   localparam logic [127:0] D1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] R1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] D2  = 128'hfedcba98765432100123456789abcdef;
   localparam logic [127:0] K2  = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] R2  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
   localparam logic [127:0] R3  = 128'hcafef00d12345678a5a5a5a55a5a5a5a;
   localparam logic [255:0] K8A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] R8A = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] K8B = 256'hffeeddccbbaa99887766554433221100deadbeef0badf00d1122334455667788;
   localparam logic [127:0] R8B = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   localparam logic [127:0] JUNK = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]   cs  = 2'b11;
   logic [1:0]   sdi = 2'b00;
   logic [1:0]   core_done = 2'b00;
   logic [127:0] core_result [2];
   wire  [1:0]   sdo, core_start, frame_done;
   wire  [0:127] data4, data8, key4;
   wire  [0:255] key8;
`ifdef AES_SPI_TIMEOUT_EN
   wire  [1:0]   err;
`endif

   aes_spi_responder #(.NK(4), .GAP(4)) dut4 (
      .clk(clk), .rst(rst), .cs(cs[0]), .sdi(sdi[0]), .sdo(sdo[0]),
      .core_start(core_start[0]), .core_data(data4), .core_key(key4),
      .core_done(core_done[0]), .core_result(core_result[0]),
      .frame_done(frame_done[0])
`ifdef AES_SPI_TIMEOUT_EN
      , .err(err[0])
`endif
   );

   aes_spi_responder #(.NK(8), .GAP(4)) dut8 (
      .clk(clk), .rst(rst), .cs(cs[1]), .sdi(sdi[1]), .sdo(sdo[1]),
      .core_start(core_start[1]), .core_data(data8), .core_key(key8),
      .core_done(core_done[1]), .core_result(core_result[1]),
      .frame_done(frame_done[1])
`ifdef AES_SPI_TIMEOUT_EN
      , .err(err[1])
`endif
   );

   // ---------------------------------------------------------------- checking
   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: event seen, none expected", name);
   endtask

   typedef struct { logic [127:0] data; logic [255:0] key; int cyc; } start_t;
   typedef struct { logic [127:0] result; int len; } done_t;
   start_t sq0[$], sq1[$];
   done_t  dq0[$], dq1[$];

   int           cyc [2];
   logic [127:0] acc [2];

   // Monitor: runs 1 ns after each rising edge, checks core_start and frame_done.
   task automatic mon(input int s);
      start_t st;
      done_t  dn;
      logic [127:0] d;
      logic [255:0] k;
      bit empty;
      if (rst) begin
         cyc[s] = 0;
         acc[s] = '0;
         return;
      end
      if (cs[s]) cyc[s] = 0; else cyc[s]++;
      acc[s] = {acc[s][126:0], sdo[s]};
      if (core_start[s]) begin
         d = (s == 0) ? data4 : data8;
         k = (s == 0) ? {key4, 128'b0} : key8;
         empty = (s == 0) ? (sq0.size() == 0) : (sq1.size() == 0);
         if (empty) fail_now($sformatf("core_start unexpected dut%0d", s));
         else begin
            st = (s == 0) ? sq0.pop_front() : sq1.pop_front();
            check($sformatf("core_data dut%0d", s), d, st.data);
            check($sformatf("core_key dut%0d", s), k, st.key);
            check($sformatf("core_start cycle dut%0d", s), cyc[s], st.cyc);
         end
      end
      if (frame_done[s]) begin
         empty = (s == 0) ? (dq0.size() == 0) : (dq1.size() == 0);
         if (empty) fail_now($sformatf("frame_done unexpected dut%0d", s));
         else begin
            dn = (s == 0) ? dq0.pop_front() : dq1.pop_front();
            check($sformatf("sdo stream dut%0d", s), acc[s], dn.result);
            check($sformatf("frame_done cycle dut%0d", s), cyc[s] + 1, dn.len);
         end
         cyc[s] = -1;  // the edge after frame_done still belongs to this frame
      end
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) mon(s);
   end

   // -------------------------------------------------------------- core model
   int           cd    [2];
   logic [127:0] cval  [2];
   bit           cmode [2];   // 1 = never answer
   bit           inject[2];   // request one stray core_done pulse

   initial forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         core_done[s] = 1'b0;
         if (inject[s]) begin
            core_done[s]   = 1'b1;
            core_result[s] = JUNK;
            inject[s]      = 1'b0;
         end else if (cd[s] > 0) begin
            cd[s]--;
            if (cd[s] == 0) begin
               core_done[s]   = 1'b1;
               core_result[s] = cval[s];
            end
         end
         if (core_start[s] && !cmode[s]) cd[s] = 2;
      end
   end

   // --------------------------------------------------------------- stimulus
   task automatic drive(input int s, input logic c, input logic d);
      @(negedge clk);
      cs[s]  = c;
      sdi[s] = d;
   endtask

   task automatic send_frame(input int s, input logic [127:0] data, input logic [255:0] key,
                             input logic [127:0] core_val, input logic [127:0] exp_tx,
                             input int inject_at);
      int nkb;
      start_t st;
      done_t  dn;
      nkb     = (s == 0) ? 128 : 256;
      cval[s] = core_val;
      st.data = data; st.key = key; st.cyc = 128 + nkb;
      dn.result = exp_tx; dn.len = 128 + nkb + 4 + 128;
      if (s == 0) begin sq0.push_back(st); dq0.push_back(dn); end
      else        begin sq1.push_back(st); dq1.push_back(dn); end
      for (int i = 0; i < 128; i++) drive(s, 1'b0, data[127-i]);
      for (int i = 0; i < nkb; i++) begin
         if (i == inject_at) inject[s] = 1'b1;
         drive(s, 1'b0, key[255-i]);
      end
      for (int i = 0; i < 4 + 128; i++) drive(s, 1'b0, 1'b0);
   endtask

   logic [127:0] tmp;
   logic [127:0] exp_miss;

   initial begin
      for (int s = 0; s < 2; s++) begin
         core_result[s] = '0; cval[s] = '0; cd[s] = 0;
         cmode[s] = 1'b0; inject[s] = 1'b0; cyc[s] = 0; acc[s] = '0;
      end
      repeat (3) @(negedge clk);

      // Reset state
      check("rst sdo", sdo, 2'b00);
      check("rst core_start", core_start, 2'b00);
      check("rst frame_done", frame_done, 2'b00);
      check("rst data4", data4, 0);
      check("rst key4", key4, 0);
      check("rst data8", data8, 0);
      check("rst key8", key8, 0);
`ifdef AES_SPI_TIMEOUT_EN
      check("rst err", err, 2'b00);
`endif
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // NK=4 reference vector
      send_frame(0, D1, {K1, 128'b0}, R1, R1, -1);
      repeat (2) drive(0, 1'b1, 1'b0);

      // NK=8, two frames back to back with cs held low
      send_frame(1, D1, K8A, R8A, R8A, -1);
      send_frame(1, D2, K8B, R8B, R8B, -1);
      repeat (2) drive(1, 1'b1, 1'b0);

      // Abort after 60 data bits, then a full frame
      for (int i = 0; i < 60; i++) drive(0, 1'b0, D2[127-i]);
      repeat (2) drive(0, 1'b1, 1'b0);
      tmp = data4;
      check("abort keeps data prefix", {196'b0, tmp[127:68]}, {196'b0, D2[127:68]});
      check("abort keeps key", key4, K1);
      send_frame(0, D2, {K2, 128'b0}, R2, R2, -1);
      repeat (2) drive(0, 1'b1, 1'b0);

      // Stray core_done in RX_KEY, real one in WAIT
      send_frame(0, D1, {K1, 128'b0}, R3, R3, 20);
      repeat (2) drive(0, 1'b1, 1'b0);

      // Core never answers
`ifdef AES_SPI_TIMEOUT_EN
      check("err before miss", err[0], 1'b0);
      exp_miss = '0;
`else
      exp_miss = R3;
`endif
      cmode[0] = 1'b1;
      send_frame(0, D2, {K2, 128'b0}, R1, exp_miss, -1);
      repeat (2) drive(0, 1'b1, 1'b0);
      cmode[0] = 1'b0;
`ifdef AES_SPI_TIMEOUT_EN
      check("err after miss", err[0], 1'b1);
`endif

      // Reset while transmitting bit 50
      begin
         start_t st;
         st.data = D1; st.key = {K1, 128'b0}; st.cyc = 256;
         sq0.push_back(st);
         cval[0] = R2;
         for (int i = 0; i < 128; i++) drive(0, 1'b0, D1[127-i]);
         for (int i = 0; i < 128; i++) drive(0, 1'b0, K1[127-i]);
         for (int i = 0; i < 4 + 50; i++) drive(0, 1'b0, 1'b0);
         @(negedge clk);
         check("tx bit 50 before rst", sdo[0], R2[77]);
         rst = 1'b1;
         #1;
         check("sdo at rst", sdo[0], 1'b0);
         check("frame_done at rst", frame_done[0], 1'b0);
         check("data4 at rst", data4, 0);
         cs[0] = 1'b1;
         repeat (3) @(negedge clk);
         check("no frame_done after rst", frame_done[0], 1'b0);
         rst = 1'b0;
         repeat (3) @(negedge clk);
      end

      check("start queue 0 drained", sq0.size(), 0);
      check("done queue 0 drained", dq0.size(), 0);
      check("start queue 1 drained", sq1.size(), 0);
      check("done queue 1 drained", dq1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
